neuron_update: RTL and testbench

NEURON_UPDATE -- requirements
Module: neuron_update

---
 rtl/neuron_update.sv | 210 +++++++++++++++++++++
 tb/tb_neuron_update.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_update.sv
// -----------------------------------------------------------------------------
// neuron_update
//
// Leaky integrate-and-fire neuron array. One membrane potential per neuron is
// kept in a single-port synchronous RAM (1-cycle read latency). Two clients
// share that RAM:
//   * the sweep generator, which reads a neuron (scan_sel=0) and writes the
//     leaked potential back on the next cycle (scan_sel=1). A neuron whose
//     leaked potential reaches THRESH is reset to 0 and its address is queued
//     in the spike FIFO.
//   * a synaptic-event FSM (IDLE -> SYN_RD -> SYN_WR) that adds a signed
//     weight to one neuron with saturation to [0, 2**POT_W-1].
//
// Ports
//   clk, reset              clock (rising edge), synchronous active-high reset
//   scan_en/scan_addr/scan_sel   sweep interface (read phase / write phase)
//   ext_req[1:0]            {fifo_full, syn_pending}: hold request to sweep gen
//   syn_valid/syn_ready     synaptic event handshake
//   syn_addr/syn_weight     target neuron and signed weight (POT_W+1 bits)
//   spk_valid/spk_ready     AER spike output handshake
//   spk_addr                address of the spiking neuron at the FIFO head
//   drop_cnt                dropped-spike counter (saturating at 255)
//
// Build option
//   NEURON_UPDATE_DROP_CNT_EN  when defined, drop_cnt counts spikes lost to a
//                              full FIFO; otherwise drop_cnt is tied to 0.
//
// RAM contents are not touched by reset; they come up as 0 from configuration.
// -----------------------------------------------------------------------------
module neuron_update #(
   parameter int NEURON_NO  = 2**8,
   parameter int POT_W      = 16,
   parameter int THRESH     = 1000,
   parameter int LEAK       = 1,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         scan_en,
   input  logic [$clog2(NEURON_NO)-1:0] scan_addr,
   input  logic                         scan_sel,
   output logic [1:0]                   ext_req,
   input  logic                         syn_valid,
   output logic                         syn_ready,
   input  logic [$clog2(NEURON_NO)-1:0] syn_addr,
   input  logic signed [POT_W:0]        syn_weight,
   output logic                         spk_valid,
   input  logic                         spk_ready,
   output logic [$clog2(NEURON_NO)-1:0] spk_addr,
   output logic [7:0]                   drop_cnt
);

   localparam int AW = $clog2(NEURON_NO);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [POT_W-1:0] LEAK_V   = POT_W'(LEAK);
   localparam logic [POT_W-1:0] THRESH_V = POT_W'(THRESH);

   typedef enum logic [1:0] {IDLE = 2'd0, SYN_RD = 2'd1, SYN_WR = 2'd2} state_t;

   // Leak with floor at zero, so a small potential never wraps around.
   function automatic logic [POT_W-1:0] leak_sub(input logic [POT_W-1:0] v);
      if (v > LEAK_V) return v - LEAK_V;
      else            return '0;
   endfunction

   // Unsigned potential plus signed weight, clamped to [0, 2**POT_W-1].
   // Two guard bits: the MSB flags a negative sum, the next one an overflow.
   function automatic logic [POT_W-1:0] sat_add(input logic [POT_W-1:0]        v,
                                                 input logic signed [POT_W:0] w);
      logic signed [POT_W+1:0] sum;
      sum = $signed({2'b00, v}) + $signed({w[POT_W], w});
      if (sum[POT_W+1])    return '0;
      else if (sum[POT_W]) return '1;
      else                 return sum[POT_W-1:0];
   endfunction

   state_t                  state;
   logic                    sweep_pend_p0;
   logic [AW-1:0]           sweep_addr_p0;
   logic [AW-1:0]           syn_addr_p0;
   logic signed [POT_W:0]   syn_weight_p0;
   logic [POT_W-1:0]        syn_sum_p1;

   logic [POT_W-1:0]        mem [NEURON_NO];
   logic [POT_W-1:0]        ram_dout;
   logic [AW-1:0]           ram_addr;
   logic [POT_W-1:0]        ram_din;
   logic                    ram_we;

   logic                    syn_hs;
   logic                    syn_wr;
   logic                    sweep_wr;
   logic                    fire;
   logic [POT_W-1:0]        leaked;

   logic [AW-1:0]           fifo_mem [FIFO_DEPTH];
   logic [PW:0]             wr_ptr;
   logic [PW:0]             rd_ptr;
   logic                    fifo_empty;
   logic                    fifo_full;
   logic                    pop;
   logic                    push_ok;

   assign syn_ready = ~reset & (state == IDLE) & ~scan_en & ~sweep_pend_p0;
   assign syn_hs    = syn_valid & syn_ready;
   assign syn_wr    = ~reset & (state == SYN_WR);
   // A write phase only acts on a neuron read in the previous cycle; the
   // synaptic write owns the RAM port if both ever coincide.
   assign sweep_wr  = ~reset & sweep_pend_p0 & scan_sel & ~syn_wr;
   assign leaked    = leak_sub(ram_dout);
   assign fire      = sweep_wr & (leaked >= THRESH_V);

   // Single RAM port arbitration: writes first, then the synaptic read,
   // otherwise the sweep address (read phase).
   always_comb begin
      ram_we   = 1'b0;
      ram_addr = scan_addr;
      ram_din  = leaked;
      if (syn_wr) begin
         ram_we   = 1'b1;
         ram_addr = syn_addr_p0;
         ram_din  = syn_sum_p1;
      end else if (sweep_wr) begin
         ram_we   = 1'b1;
         ram_addr = sweep_addr_p0;
         ram_din  = (leaked >= THRESH_V) ? '0 : leaked;
      end else if (syn_hs) begin
         ram_addr = syn_addr;
      end
   end

   // ---- stage p0: RAM access (read data valid one cycle later) ----
   always_ff @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) sweep_pend_p0 <= 1'b0;
      else       sweep_pend_p0 <= scan_en & ~scan_sel & ~syn_wr;
   end

   always_ff @(posedge clk) begin
      if (scan_en & ~scan_sel) sweep_addr_p0 <= scan_addr;
      if (syn_hs) begin
         syn_addr_p0   <= syn_addr;
         syn_weight_p0 <= syn_weight;
      end
   end

   // ---- stage p1: saturated synaptic sum, written back in SYN_WR ----
   always_ff @(posedge clk) begin
      if (state == SYN_RD) syn_sum_p1 <= sat_add(ram_dout, syn_weight_p0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (syn_hs) state <= SYN_RD;
            SYN_RD:  state <= SYN_WR;
            SYN_WR:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // ---- spike FIFO: extra pointer bit separates full from empty ----
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign spk_valid  = ~reset & ~fifo_empty;
   assign spk_addr   = spk_valid ? fifo_mem[rd_ptr[PW-1:0]] : '0;
   assign pop        = spk_valid & spk_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push_ok    = fire & (~fifo_full | pop);

   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr[PW-1:0]] <= sweep_addr_p0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign ext_req = reset ? 2'b00 : {fifo_full, syn_valid | (state != IDLE)};

`ifdef NEURON_UPDATE_DROP_CNT_EN
   logic       drop;
   logic [7:0] drop_q;

   assign drop = fire & fifo_full & ~pop;

   always_ff @(posedge clk) begin
      if (reset)                      drop_q <= '0;
      else if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
   end

   assign drop_cnt = drop_q;
`else
   assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_neuron_update.sv
// -----------------------------------------------------------------------------
// tb_neuron_update
//
// Directed testbench for neuron_update with default parameters
// (256 neurons, 16-bit potentials, THRESH=1000, LEAK=1, 8-deep spike FIFO).
// Potentials are preloaded through the synaptic port: a weight of -65536
// clamps any value to 0, then a positive weight sets the wanted value.
// -----------------------------------------------------------------------------
module tb_neuron_update;

   logic              clk = 1'b0;
   logic              reset;
   logic              scan_en;
   logic [7:0]        scan_addr;
   logic              scan_sel;
   logic [1:0]        ext_req;
   logic              syn_valid;
   logic              syn_ready;
   logic [7:0]        syn_addr;
   logic signed [16:0] syn_weight;
   logic              spk_valid;
   logic              spk_ready;
   logic [7:0]        spk_addr;
   logic [7:0]        drop_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   neuron_update dut (
      .clk        (clk),
      .reset      (reset),
      .scan_en    (scan_en),
      .scan_addr  (scan_addr),
      .scan_sel   (scan_sel),
      .ext_req    (ext_req),
      .syn_valid  (syn_valid),
      .syn_ready  (syn_ready),
      .syn_addr   (syn_addr),
      .syn_weight (syn_weight),
      .spk_valid  (spk_valid),
      .spk_ready  (spk_ready),
      .spk_addr   (spk_addr),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Synaptic event; optional checks of the handshake side signals.
   task automatic syn(input logic [7:0] a, input int w, input bit chk);
      @(negedge clk);
      syn_valid  = 1'b1;
      syn_addr   = a;
      syn_weight = 17'(w);
      #1;
      if (chk) begin
         check("syn_ext_req0_valid", 32'(ext_req[0]), 1);
         check("syn_ready_idle", 32'(syn_ready), 1);
      end
      @(posedge clk);
      @(negedge clk);
      syn_valid = 1'b0;
      #1;
      if (chk) begin
         check("syn_ext_req0_busy", 32'(ext_req[0]), 1);
         check("syn_ready_busy", 32'(syn_ready), 0);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [7:0] a, input int v);
      syn(a, -65536, 1'b0);
      if (v > 0) syn(a, v, 1'b0);
   endtask

   // One read/write sweep of a neuron; pop_wr raises spk_ready in the write cycle.
   task automatic sweep(input logic [7:0] a, input bit pop_wr);
      @(negedge clk);
      scan_en   = 1'b1;
      scan_sel  = 1'b0;
      scan_addr = a;
      @(negedge clk);
      scan_sel = 1'b1;
      if (pop_wr) spk_ready = 1'b1;
      @(negedge clk);
      scan_en   = 1'b0;
      scan_sel  = 1'b0;
      spk_ready = 1'b0;
      #1;
   endtask

   task automatic drain(input logic [7:0] exp_addr [8]);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         spk_ready = 1'b1;
         #1;
         check($sformatf("drain_valid_%0d", i), 32'(spk_valid), 1);
         check($sformatf("drain_addr_%0d", i), 32'(spk_addr), 32'(exp_addr[i]));
      end
      @(negedge clk);
      spk_ready = 1'b0;
      #1;
      check("drain_empty", 32'(spk_valid), 0);
      check("drain_not_full", 32'(ext_req[1]), 0);
   endtask

   logic [7:0] fire_a [10];
   logic [7:0] exp_a  [8];
   logic [7:0] exp_b  [8];
   int         exp_drop;

   initial begin
      fire_a = '{8'd255, 8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27, 8'd28};
      exp_a  = '{8'd255, 8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26};
      exp_b  = '{8'd41, 8'd42, 8'd43, 8'd44, 8'd45, 8'd46, 8'd47, 8'd48};
`ifdef NEURON_UPDATE_DROP_CNT_EN
      exp_drop = 2;
`else
      exp_drop = 0;
`endif

      // Reset state, with syn_valid asserted to show reset masks it.
      reset      = 1'b1;
      scan_en    = 1'b0;
      scan_addr  = '0;
      scan_sel   = 1'b0;
      syn_valid  = 1'b1;
      syn_addr   = '0;
      syn_weight = '0;
      spk_ready  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_syn_ready", 32'(syn_ready), 0);
      check("rst_ext_req", 32'(ext_req), 0);
      check("rst_spk_valid", 32'(spk_valid), 0);
      check("rst_spk_addr", 32'(spk_addr), 0);
      check("rst_drop_cnt", 32'(drop_cnt), 0);
      reset     = 1'b0;
      syn_valid = 1'b0;

      // Leak below threshold: 1000 -> 999, no spike.
      preload(8'd5, 1000);
      check("pre5", 32'(dut.mem[5]), 1000);
      sweep(8'd5, 1'b0);
      check("leak5", 32'(dut.mem[5]), 999);
      check("leak5_nospk", 32'(spk_valid), 0);

      // 1001 leaks to 1000 = THRESH: spike and reset.
      preload(8'd7, 1001);
      sweep(8'd7, 1'b0);
      check("fire7_valid", 32'(spk_valid), 1);
      check("fire7_addr", 32'(spk_addr), 7);
      check("fire7_mem", 32'(dut.mem[7]), 0);
      @(negedge clk);
      spk_ready = 1'b1;
      @(negedge clk);
      spk_ready = 1'b0;
      #1;
      check("fire7_popped", 32'(spk_valid), 0);

      // Zero potential does not underflow.
      preload(8'd3, 0);
      sweep(8'd3, 1'b0);
      check("zero3_mem", 32'(dut.mem[3]), 0);
      check("zero3_nospk", 32'(spk_valid), 0);

      // Write phase without a preceding read must not write.
      preload(8'd70, 500);
      @(negedge clk);
      scan_en   = 1'b1;
      scan_sel  = 1'b1;
      scan_addr = 8'd70;
      @(negedge clk);
      scan_en  = 1'b0;
      scan_sel = 1'b0;
      #1;
      check("orphan_wr70", 32'(dut.mem[70]), 500);

      // Synaptic saturation both ways.
      preload(8'd9, 10);
      syn(8'd9, 65535, 1'b1);
      check("syn9_sat_hi", 32'(dut.mem[9]), 65535);
      preload(8'd9, 10);
      syn(8'd9, -20, 1'b1);
      check("syn9_sat_lo", 32'(dut.mem[9]), 0);
      syn(8'd9, 300, 1'b0);
      check("syn9_add", 32'(dut.mem[9]), 300);

      // syn_ready is held low during a sweep.
      @(negedge clk);
      scan_en   = 1'b1;
      scan_sel  = 1'b0;
      scan_addr = 8'd3;
      #1;
      check("ready_scan_rd", 32'(syn_ready), 0);
      @(negedge clk);
      scan_sel = 1'b1;
      #1;
      check("ready_scan_wr", 32'(syn_ready), 0);
      @(negedge clk);
      scan_en  = 1'b0;
      scan_sel = 1'b0;
      #1;
      check("ready_after_scan", 32'(syn_ready), 1);

      // Overflow: 10 spikes into 8 slots, last address included.
      for (int i = 0; i < 10; i++) begin
         preload(fire_a[i], 2000);
         sweep(fire_a[i], 1'b0);
      end
      check("ovf_full", 32'(ext_req[1]), 1);
      check("ovf_valid", 32'(spk_valid), 1);
      check("ovf_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
      check("ovf_mem255", 32'(dut.mem[255]), 0);
      check("ovf_mem28_dropped", 32'(dut.mem[28]), 0);
      drain(exp_a);

      // Full FIFO with simultaneous pop and push: nothing dropped.
      for (int i = 0; i < 8; i++) begin
         preload(8'(40 + i), 2000);
         sweep(8'(40 + i), 1'b0);
      end
      check("full_b", 32'(ext_req[1]), 1);
      preload(8'd48, 2000);
      sweep(8'd48, 1'b1);
      check("pushpop_full", 32'(ext_req[1]), 1);
      check("pushpop_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
      check("pushpop_mem48", 32'(dut.mem[48]), 0);
      drain(exp_b);

      // Reset right after a sweep read of a firing neuron.
      preload(8'd61, 2000);
      sweep(8'd61, 1'b0);
      check("pre_rst_valid", 32'(spk_valid), 1);
      preload(8'd60, 2000);
      @(negedge clk);
      scan_en   = 1'b1;
      scan_sel  = 1'b0;
      scan_addr = 8'd60;
      @(negedge clk);
      scan_sel = 1'b1;
      reset    = 1'b1;
      @(negedge clk);
      reset    = 1'b0;
      scan_en  = 1'b0;
      scan_sel = 1'b0;
      #1;
      check("rst_mid_mem60", 32'(dut.mem[60]), 2000);
      check("rst_mid_valid", 32'(spk_valid), 0);
      check("rst_mid_addr", 32'(spk_addr), 0);
      check("rst_mid_ext_req", 32'(ext_req), 0);
      check("rst_mid_drop_cnt", 32'(drop_cnt), 0);
      check("rst_mid_ready", 32'(syn_ready), 1);
      repeat (2) @(negedge clk);
      #1;
      check("rst_mid_mem60_hold", 32'(dut.mem[60]), 2000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
